// File: rtl/debug_dump_unit_pkg.sv
// Shared definitions for the debug dump unit: FSM state encoding, frame
// framing constants and a frame-length helper.
package debug_dump_unit_pkg;

  // Frame sequencing states. IDLE is all-zero so a cleared register is idle.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_HEADER   = 3'd2,
    ST_PC_SEND  = 3'd3,
    ST_LOAD     = 3'd4,
    ST_REG_SEND = 3'd5,
    ST_CKSUM    = 3'd6
  } dump_state_e;

  // First byte of every frame, lets the host resynchronise on the stream.
  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  // Default register count dumped by the unit.
  localparam int DEFAULT_NUM_REGS = 32;

  // Total frame length: header + checksum + PC word + one word per register.
  function automatic int frame_bytes(input int num_regs);
    return 2 + 4 + 4 * num_regs;
  endfunction

  localparam int FRAME_BYTES = 2 + 4 + 4 * DEFAULT_NUM_REGS;

endpackage

// File: rtl/debug_dump_unit_word_byte_serializer.sv
// Word buffer for the dump unit: holds one 32-bit word (PC or register) and
// walks its bytes least-significant first. Exposes the current byte, the byte
// after it, and a flag marking the last byte of the word.
module debug_dump_unit_word_byte_serializer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        adv_i,
  input  logic [31:0] word_i,
  output logic [7:0]  byte_o,
  output logic [7:0]  next_byte_o,
  output logic        last_o
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;
  logic [1:0]  idx_next_s;

  assign idx_next_s = idx_q + 2'd1;
  assign last_o     = (idx_q == 2'd3);

  // Word buffer and byte index: load restarts at byte 0, advance steps one byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= 32'd0;
      idx_q  <= 2'd0;
    end else if (load_i) begin
      word_q <= word_i;
      idx_q  <= 2'd0;
    end else if (adv_i) begin
      idx_q  <= idx_next_s;
    end else begin
      idx_q  <= idx_q;
    end
  end

  // Little-endian byte select for the current index.
  always_comb begin
    byte_o = 8'd0;
    case (idx_q)
      2'd0:    byte_o = word_q[7:0];
      2'd1:    byte_o = word_q[15:8];
      2'd2:    byte_o = word_q[23:16];
      2'd3:    byte_o = word_q[31:24];
      default: byte_o = 8'd0;
    endcase
  end

  // Byte that follows the current one, so the FSM can preload TxData with no
  // bubble between consecutive bytes of a word.
  always_comb begin
    next_byte_o = 8'd0;
    case (idx_next_s)
      2'd0:    next_byte_o = word_q[7:0];
      2'd1:    next_byte_o = word_q[15:8];
      2'd2:    next_byte_o = word_q[23:16];
      2'd3:    next_byte_o = word_q[31:24];
      default: next_byte_o = 8'd0;
    endcase
  end

endmodule

// File: rtl/debug_dump_unit.sv
// Debug dump unit for the pipelined MIPS core. On a DumpReq rising edge it
// stalls fetch, waits for the pipeline to drain, then streams a framed snapshot
// (header, PC, all registers, XOR checksum) over a valid/ready byte interface.
module debug_dump_unit
  import debug_dump_unit_pkg::*;
#(
  parameter int NUM_REGS      = DEFAULT_NUM_REGS,
  parameter int ADDR_W        = 5,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              ClockIn,
  input  logic              Reset,
  input  logic              DumpReq,
  input  logic [31:0]       PCIn,
  output logic [ADDR_W-1:0] RegReadAddr,
  input  logic [31:0]       RegReadData,
  output logic              HaltOut,
  output logic [7:0]        TxData,
  output logic              TxValid,
  input  logic              TxReady,
  output logic              Busy,
  output logic              Done
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state_q;
  logic [CNT_W-1:0]  settle_cnt_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [7:0]        checksum_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              halt_q;
  logic              busy_q;
  logic              done_q;
  logic              dump_req_q;

  logic              xfer_s;
  logic              req_s;
  logic              settle_last_s;
  logic              ser_load_s;
  logic              ser_adv_s;
  logic [31:0]       ser_word_s;
  logic [7:0]        ser_byte_s;
  logic [7:0]        ser_next_byte_s;
  logic              ser_last_s;

  assign xfer_s        = tx_valid_q & TxReady;
  assign req_s         = DumpReq & ~dump_req_q;
  assign settle_last_s = (settle_cnt_q == SETTLE_LAST);

  assign RegReadAddr = reg_addr_q;
  assign HaltOut     = halt_q;
  assign TxData      = tx_data_q;
  assign TxValid     = tx_valid_q;
  assign Busy        = busy_q;
  assign Done        = done_q;

  // Word buffer control: capture PC at the end of settling, capture each
  // register in LOAD, and step through bytes as they are accepted.
  always_comb begin
    ser_load_s = 1'b0;
    ser_adv_s  = 1'b0;
    ser_word_s = 32'd0;
    case (state_q)
      ST_SETTLE: begin
        if (settle_last_s) begin
          ser_load_s = 1'b1;
          ser_word_s = PCIn;
        end else begin
          ser_load_s = 1'b0;
        end
      end
      ST_LOAD: begin
        ser_load_s = 1'b1;
        ser_word_s = RegReadData;
      end
      ST_PC_SEND, ST_REG_SEND: begin
        if (xfer_s && !ser_last_s) begin
          ser_adv_s = 1'b1;
        end else begin
          ser_adv_s = 1'b0;
        end
      end
      default: begin
        ser_load_s = 1'b0;
        ser_adv_s  = 1'b0;
      end
    endcase
  end

  debug_dump_unit_word_byte_serializer u_ser (
    .clk_i       (ClockIn),
    .rst_ni      (Reset),
    .load_i      (ser_load_s),
    .adv_i       (ser_adv_s),
    .word_i      (ser_word_s),
    .byte_o      (ser_byte_s),
    .next_byte_o (ser_next_byte_s),
    .last_o      (ser_last_s)
  );

  // Frame sequencer: state, halt/busy/done flags, byte output register,
  // register index, settle counter, running checksum and request edge detect.
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      reg_addr_q   <= '0;
      checksum_q   <= 8'd0;
      tx_data_q    <= 8'd0;
      tx_valid_q   <= 1'b0;
      halt_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dump_req_q   <= 1'b0;
    end else begin
      dump_req_q <= DumpReq;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_s) begin
            state_q      <= ST_SETTLE;
            halt_q       <= 1'b1;
            busy_q       <= 1'b1;
            settle_cnt_q <= '0;
            checksum_q   <= 8'd0;
          end
        end
        ST_SETTLE: begin
          if (settle_last_s) begin
            state_q    <= ST_HEADER;
            tx_valid_q <= 1'b1;
            tx_data_q  <= HEADER_BYTE;
          end else begin
            settle_cnt_q <= settle_cnt_q + CNT_W'(1);
          end
        end
        ST_HEADER: begin
          if (xfer_s) begin
            state_q   <= ST_PC_SEND;
            tx_data_q <= ser_byte_s;
          end
        end
        ST_PC_SEND: begin
          if (xfer_s) begin
            checksum_q <= checksum_q ^ tx_data_q;
            if (ser_last_s) begin
              state_q    <= ST_LOAD;
              tx_valid_q <= 1'b0;
              reg_addr_q <= '0;
            end else begin
              tx_data_q  <= ser_next_byte_s;
            end
          end
        end
        ST_LOAD: begin
          // Read data is combinational from the register file, so byte 0 of
          // the word can be presented straight away.
          state_q    <= ST_REG_SEND;
          tx_valid_q <= 1'b1;
          tx_data_q  <= RegReadData[7:0];
        end
        ST_REG_SEND: begin
          if (xfer_s) begin
            checksum_q <= checksum_q ^ tx_data_q;
            if (!ser_last_s) begin
              tx_data_q <= ser_next_byte_s;
            end else if (reg_addr_q == ADDR_LAST) begin
              // The final payload byte is folded in here so the checksum
              // byte is ready in the same cycle.
              state_q   <= ST_CKSUM;
              tx_data_q <= checksum_q ^ tx_data_q;
            end else begin
              state_q    <= ST_LOAD;
              tx_valid_q <= 1'b0;
              reg_addr_q <= reg_addr_q + ADDR_W'(1);
            end
          end
        end
        ST_CKSUM: begin
          if (xfer_s) begin
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'd0;
            halt_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          tx_valid_q <= 1'b0;
          halt_q     <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule
